// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: pointer defaults and Gray/binary
// conversion used by both the write- and read-side controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE_DEF = 2;
  localparam int AFULL_THRESH_DEF   = 3;
  localparam int PTR_MAX            = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(
    input logic [PTR_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero-padded upper bits fold away, so any width <= PTR_MAX works.
  function automatic logic [PTR_MAX-1:0] gray2bin(
    input logic [PTR_MAX-1:0] g
  );
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO bundle: producer request, RAM drive, pointers, flags.
// master = write controller, slave = producer/RAM/read-side environment.
interface fifo_wr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int FIFO_addr_size = FIFO_ADDR_SIZE_DEF
);

  logic                      w_req;
  logic [FIFO_addr_size:0]   r_ptr_gray;
  logic                      w_en;
  logic [FIFO_addr_size-1:0] w_addr;
  logic [FIFO_addr_size:0]   w_ptr_gray;
  logic                      full;
  logic                      w_overflow;
  logic                      almost_full;
  logic [FIFO_addr_size:0]   w_count;

  modport master (
    input  w_req, r_ptr_gray,
    output w_en, w_addr, w_ptr_gray, full,
    output w_overflow, almost_full, w_count
  );

  modport slave (
    output w_req, r_ptr_gray,
    input  w_en, w_addr, w_ptr_gray, full,
    input  w_overflow, almost_full, w_count
  );

endinterface

// File: rtl/fifo_sync_2ff.sv
// Generic WIDTH-bit two-stage synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module fifo_sync_2ff #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Dual-clock FIFO write controller (clk_w domain): pointers, rptr sync,
// full/overflow, RAM drive. Ports: clk_w, rst_w (async low), wif.master.
// Option FIFO_WCOUNT_EN: registered w_count and almost_full.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int          FIFO_addr_size = FIFO_ADDR_SIZE_DEF,
  parameter int unsigned AFULL_THRESH   = AFULL_THRESH_DEF
) (
  input  logic           clk_w,
  input  logic           rst_w,
  fifo_wr_ctrl_if.master wif
);

  localparam int A  = FIFO_addr_size;
  localparam int PW = A + 1;

  logic [A:0] w_bin;
  logic [A:0] w_bin_next;
  logic [A:0] gray_next;
  logic [A:0] w_gray;
  logic [A:0] rq2;
  logic [A:0] full_tgt;
  logic       full_q;
  logic       ovf_q;
  logic       accept;

  fifo_sync_2ff #(
    .WIDTH (PW)
  ) u_rsync (
    .clk   (clk_w),
    .rst_n (rst_w),
    .d     (wif.r_ptr_gray),
    .q     (rq2)
  );

  assign accept     = wif.w_req & ~full_q;
  assign w_bin_next = w_bin + {{A{1'b0}}, accept};
  assign gray_next  = PW'(bin2gray(PTR_MAX'(w_bin_next)));

  // Full when write is one lap ahead: top two Gray bits inverted.
  assign full_tgt = {~rq2[A:A-1], rq2[A-2:0]};

  always_ff @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      w_bin  <= '0;
      w_gray <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      w_bin  <= w_bin_next;
      w_gray <= gray_next;
      full_q <= (gray_next == full_tgt);
      ovf_q  <= wif.w_req & full_q;
    end
  end

  assign wif.w_en       = accept;
  assign wif.w_addr     = w_bin[A-1:0];
  assign wif.w_ptr_gray = w_gray;
  assign wif.full       = full_q;
  assign wif.w_overflow = ovf_q;

`ifdef FIFO_WCOUNT_EN
  logic [A:0] rbin;
  logic [A:0] cnt_next;
  logic [A:0] cnt_q;
  logic       af_q;

  assign rbin     = PW'(gray2bin(PTR_MAX'(rq2)));
  assign cnt_next = w_bin_next - rbin;

  always_ff @(posedge clk_w or negedge rst_w) begin
    if (!rst_w) begin
      cnt_q <= '0;
      af_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      af_q  <= (PTR_MAX'(cnt_next) >= AFULL_THRESH);
    end
  end

  assign wif.w_count     = cnt_q;
  assign wif.almost_full = af_q;
`else
  assign wif.w_count     = '0;
  assign wif.almost_full = 1'b0;
`endif

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller of the dual-clock FIFO. It runs entirely in the clk_w domain and owns the following:
- the binary and Gray write pointers;
- the 2-FF synchronizer for the read pointer (Gray) arriving from the clk_r domain;
- full / overflow generation;
- the w_en / w_addr / full drive into the FIFO storage RAM.

The mirror read-side controller drives r_addr and r_ptr_gray.

Parameters:
FIFO_addr_size, 2, RAM address width; depth = 2**FIFO_addr_size; must be >= 2.
AFULL_THRESH, 3, occupancy at or above which almost_full asserts (used only with FIFO_WCOUNT_EN).

Ports:
clk_w  input  1  write-domain clock.
rst_w  input  1  asynchronous, active-low reset of all state in this block.
w_req  input  1  producer write request, one word per cycle while high.
r_ptr_gray  input  FIFO_addr_size+1  read pointer (Gray) from the clk_r domain; asynchronous to clk_w.
w_en  output  1  write strobe to the RAM; = w_req & ~full (combinational).
w_addr  output  FIFO_addr_size  RAM write address; = w_bin[FIFO_addr_size-1:0].
w_ptr_gray  output  FIFO_addr_size+1  registered write pointer (Gray), sent to the read-side synchronizer.
full  output  1  registered full flag; also wired to the RAM full input.
w_overflow  output  1  one-cycle pulse: a w_req was rejected because full was high.
almost_full  output  1  occupancy >= AFULL_THRESH (feature-dependent).
w_count  output  FIFO_addr_size+1  write-side occupancy estimate (feature-dependent).

Behaviour:
- Reset (rst_w low, asynchronous, takes effect without a clock):
  - w_bin, w_ptr_gray, both synchronizer stages, full, w_overflow, almost_full and w_count all go to 0.
  - w_addr therefore = 0.
  - w_en = w_req, because full = 0.
- Pointer width is A+1 bits, where A = FIFO_addr_size. The extra MSB is the wrap bit.
- Accept: when w_req=1 and full=0 at a clk_w edge:
  - w_bin_next = w_bin + 1, wrapping modulo 2**(A+1).
  - w_ptr_gray <= w_bin_next ^ (w_bin_next >> 1).
  - Only one pointer bit of w_ptr_gray changes per accept.
- Reject: when w_req=1 and full=1:
  - pointers hold;
  - w_en=0;
  - w_overflow=1 for the next cycle only.
- Synchronizer: rq1 <= r_ptr_gray; rq2 <= rq1. Both registers are reset to 0. Nothing else samples r_ptr_gray.
- Full: registered.
  - full <= (gray_next == {~rq2[A:A-1], rq2[A-2:0]}).
  - gray_next is the post-accept Gray value, or the current value if there is no accept.
  - full asserts on the same edge that accepts the last free slot. A write can therefore never land on an occupied slot.
- Release latency: a change on r_ptr_gray can clear full no earlier than the 3rd clk_w edge after it is stable (rq1, rq2, then full). This is pessimistic by design and always safe.
- Simultaneous w_req and a read-pointer release on the same edge: the decision uses the old full value. The write is rejected if full=1 at that edge.
- No combinational path from r_ptr_gray to any output.
- Mid-operation reset clears the pointers immediately. The read domain must be reset in the same window; resetting only one side is unsupported.

Optional Feature:
FIFO_WCOUNT_EN
- Defined:
  - the synchronized rq2 is converted from Gray to binary (rbin);
  - w_count <= w_bin_next - rbin, modulo 2**(A+1), registered;
  - almost_full <= (w_count_next >= AFULL_THRESH), registered;
  - both outputs update on the same edge as full.
- Undefined: w_count and almost_full are tied to 0, and no Gray-to-binary logic is instantiated.

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray;
  - function gray2bin (parameterised width via a loop over bits);
  - localparam defaults for FIFO_addr_size.
  The read-side controller shares the same package.
- One sub-module: fifo_sync_2ff.
  - Generic WIDTH-bit, two-stage synchronizer with async active-low reset to 0.
  - Instantiated here for r_ptr_gray; reused by the read side for w_ptr_gray.

Test Plan:
All scenarios use FIFO_addr_size=2, depth 4, 3-bit pointers.
1. Assert rst_w low with no clock -> full=0, w_ptr_gray=000, w_addr=0, w_overflow=0, w_count=0 immediately.
2. r_ptr_gray=000, w_req high for 5 cycles:
   - w_en=1 and w_addr=0,1,2,3 on the first 4 cycles;
   - w_ptr_gray=001,011,010,110;
   - full=1 after the 4th edge;
   - 5th cycle: w_en=0, w_overflow pulses 1 cycle, w_ptr_gray stays 110.
3. From full, drive r_ptr_gray=001 -> full stays 1 through edges 1-2 and is 0 after edge 3. One more w_req is accepted (w_addr=0, w_ptr_gray=111) and full returns to 1.
4. Wrap-around: 8 accepts with r_ptr_gray trailing by <=2 words -> w_addr sequence 0,1,2,3,0,1,2,3; w_ptr_gray returns to 000; full never asserts.
5. Pulse rst_w low mid-burst while full=1 -> all outputs clear asynchronously. After release, a write is accepted at w_addr=0 on the first edge.
6. FIFO_WCOUNT_EN defined, AFULL_THRESH=3, r_ptr_gray=000, 3 accepts -> w_count=3 and almost_full=1 after the 3rd edge. Undefined build: both remain 0.
